mdu_ctrl: RTL

- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core; sits in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from the controller decode and models configurable mult/div latency with a countdown counter.
- Exports busy/stall information to the hazard unit.
- Generalises the single-cycle decode path with width and latency parameters.

---
 rtl/mdu_ctrl_if.sv | 23 ++
 rtl/mdu_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - E-stage MDU request/result bundle between decode/hazard logic and the MDU
interface mdu_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             md_stall;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   modport master (
      output start, op, A, B,
      input  busy, md_stall, HI, LO
   );

   modport slave (
      input  start, op, A, B,
      output busy, md_stall, HI, LO
   );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle mult/div unit with HI/LO registers and hazard stall output
// Results are computed at issue and held in pending regs; a countdown models the unit latency.
module mdu_ctrl #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       reset,
   mdu_ctrl_if.slave  mdu
);
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] W_ZERO   = '0;
   localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] phi_q, phi_d;
   logic [WIDTH-1:0] plo_q, plo_d;

   logic               is_mul, is_div;
   logic [2*WIDTH-1:0] mul_a, mul_b, prod;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   abs_a, abs_b, div_b, uq, ur, quo, rem;

   // Signed ops go through magnitudes so truncation is toward zero; MIN/-1 wraps naturally.
   always_comb begin
      is_mul = (mdu.op == OP_MULT) || (mdu.op == OP_MULTU);
      is_div = (mdu.op == OP_DIV)  || (mdu.op == OP_DIVU);

      mul_a = (mdu.op == OP_MULT) ? {{WIDTH{mdu.A[WIDTH-1]}}, mdu.A} : {W_ZERO, mdu.A};
      mul_b = (mdu.op == OP_MULT) ? {{WIDTH{mdu.B[WIDTH-1]}}, mdu.B} : {W_ZERO, mdu.B};
      prod  = mul_a * mul_b;

      a_neg = (mdu.op == OP_DIV) && mdu.A[WIDTH-1];
      b_neg = (mdu.op == OP_DIV) && mdu.B[WIDTH-1];
      abs_a = a_neg ? (W_ZERO - mdu.A) : mdu.A;
      abs_b = b_neg ? (W_ZERO - mdu.B) : mdu.B;
      div_b = (abs_b == W_ZERO) ? W_ONE : abs_b;
      uq    = abs_a / div_b;
      ur    = abs_a % div_b;
      quo   = (a_neg ^ b_neg) ? (W_ZERO - uq) : uq;
      rem   = a_neg ? (W_ZERO - ur) : ur;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      case (state_q)
         IDLE: begin
            if (mdu.start) begin
               case (mdu.op)
                  OP_MULT, OP_MULTU: begin
                     phi_d   = prod[2*WIDTH-1:WIDTH];
                     plo_d   = prod[WIDTH-1:0];
                     cnt_d   = MULT_CNT;
                     state_d = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     if (mdu.B != W_ZERO) begin
                        phi_d   = rem;
                        plo_d   = quo;
                        cnt_d   = DIV_CNT;
                        state_d = RUN;
                     end
                  end
                  OP_MTHI: hi_d = mdu.A;
                  OP_MTLO: lo_d = mdu.A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               hi_d    = phi_q;
               lo_d    = plo_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
      end
   end

   assign mdu.busy     = (state_q == RUN);
   assign mdu.md_stall = (state_q == RUN) || (mdu.start && (is_mul || is_div));
   assign mdu.HI       = hi_q;
   assign mdu.LO       = lo_q;
endmodule
